// File: rtl/line_window_generator.sv
// line_window_generator: raster-stream WIDTH x HEIGHT window builder with position tracking.
// Optional build macro WINDOW_ZERO_PAD_EN: zero-padded border windows, valid on every pixel.
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef FRAME_WIDTH
`define FRAME_WIDTH 640
`endif
`ifndef FRAME_HEIGHT
`define FRAME_HEIGHT 480
`endif

module line_window_generator #(
  parameter int WORD_SIZE    = `WORD_SIZE,
  parameter int WIDTH        = 3,
  parameter int HEIGHT       = 3,
  parameter int FRAME_WIDTH  = `FRAME_WIDTH,
  parameter int FRAME_HEIGHT = `FRAME_HEIGHT,
  parameter int ADDR_WIDTH   = 11
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                en,
  input  logic                                sof,
  input  logic [WORD_SIZE-1:0]                din,
  output logic [WIDTH*HEIGHT*WORD_SIZE-1:0]   dout,
  output logic                                dout_valid,
  output logic [ADDR_WIDTH-1:0]               col_out,
  output logic [ADDR_WIDTH-1:0]               row_out,
  output logic                                frame_end
);

  localparam int NUM_LB = (HEIGHT > 1) ? HEIGHT - 1 : 1;
  localparam int LB_AW  = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] C_COL_LAST = ADDR_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] C_ROW_LAST = ADDR_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] C_COL_MIN  = ADDR_WIDTH'(WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] C_ROW_MIN  = ADDR_WIDTH'(HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] C_ONE      = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] w_pix_col, w_pix_row;
  logic [ADDR_WIDTH-1:0] col_out_q, row_out_q;
  logic                  dout_valid_q, dout_valid_d;
  logic                  frame_end_q, frame_end_d;
  logic [WORD_SIZE-1:0]  win_q [HEIGHT][WIDTH];
  logic [WORD_SIZE-1:0]  w_lb_rd [NUM_LB];
  logic [LB_AW-1:0]      w_lb_addr;

  // A sof pixel is forced to (0,0); everything downstream works on this position.
  always_comb begin
    w_pix_col = sof ? '0 : col_q;
    w_pix_row = sof ? '0 : row_q;
    col_d     = col_q;
    row_d     = row_q;
    if (en) begin
      if (w_pix_col == C_COL_LAST) begin
        col_d = '0;
        row_d = (w_pix_row == C_ROW_LAST) ? '0 : w_pix_row + C_ONE;
      end else begin
        col_d = w_pix_col + C_ONE;
        row_d = w_pix_row;
      end
    end
  end

  assign w_lb_addr = w_pix_col[LB_AW-1:0];

  always_comb begin
`ifdef WINDOW_ZERO_PAD_EN
    dout_valid_d = en;
`else
    dout_valid_d = en && (w_pix_row >= C_ROW_MIN) && (w_pix_col >= C_COL_MIN);
`endif
    frame_end_d  = en && (w_pix_row == C_ROW_LAST) && (w_pix_col == C_COL_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q        <= '0;
      row_q        <= '0;
      col_out_q    <= '0;
      row_out_q    <= '0;
      dout_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      for (int i = 0; i < HEIGHT; i++) begin
        for (int j = 0; j < WIDTH; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      dout_valid_q <= dout_valid_d;
      frame_end_q  <= frame_end_d;
      if (en) begin
        col_out_q <= w_pix_col;
        row_out_q <= w_pix_row;
        for (int i = 0; i < HEIGHT; i++) begin
          for (int j = WIDTH - 1; j > 0; j--) begin
            win_q[i][j] <= win_q[i][j-1];
          end
        end
        win_q[0][0] <= din;
        for (int i = 1; i < HEIGHT; i++) begin
          win_q[i][0] <= w_lb_rd[i-1];
        end
      end
    end
  end

  // Buffers form a chain: each one delays a column's pixel by exactly one line.
  generate
    if (HEIGHT > 1) begin : g_lb
      for (genvar k = 0; k < HEIGHT - 1; k++) begin : g_buf
        logic [WORD_SIZE-1:0] mem [FRAME_WIDTH];
        logic [WORD_SIZE-1:0] w_wr_data;

        assign w_lb_rd[k] = mem[w_lb_addr];

        if (k == 0) begin : g_first
          assign w_wr_data = din;
        end else begin : g_chain
          assign w_wr_data = w_lb_rd[k-1];
        end

        always_ff @(posedge clk) begin
          if (en) begin
            mem[w_lb_addr] <= w_wr_data;
          end
        end
      end
    end else begin : g_no_lb
      assign w_lb_rd[0] = '0;
    end
  endgenerate

  generate
    for (genvar i = 0; i < HEIGHT; i++) begin : g_row
      for (genvar j = 0; j < WIDTH; j++) begin : g_col
        localparam int LANE = i * WIDTH + j;
`ifdef WINDOW_ZERO_PAD_EN
        logic w_row_pad, w_col_pad;
        if (i == 0) begin : g_r0
          assign w_row_pad = 1'b0;
        end else begin : g_rn
          assign w_row_pad = (row_out_q < ADDR_WIDTH'(i));
        end
        if (j == 0) begin : g_c0
          assign w_col_pad = 1'b0;
        end else begin : g_cn
          assign w_col_pad = (col_out_q < ADDR_WIDTH'(j));
        end
        assign dout[(LANE+1)*WORD_SIZE-1 -: WORD_SIZE] =
          (w_row_pad || w_col_pad) ? '0 : win_q[i][j];
`else
        assign dout[(LANE+1)*WORD_SIZE-1 -: WORD_SIZE] = win_q[i][j];
`endif
      end
    end
  endgenerate

  assign dout_valid = dout_valid_q;
  assign frame_end  = frame_end_q;
  assign col_out    = col_out_q;
  assign row_out    = row_out_q;

endmodule

`default_nettype wire

// File: tb/tb_line_window_generator.sv
// tb_line_window_generator: random-gap stream bench for line_window_generator with an image-array model.
`default_nettype none

module tb_line_window_generator;

  localparam int WS = 8;
  localparam int W  = 3;
  localparam int H  = 3;
  localparam int FW = 8;
  localparam int FH = 6;
  localparam int AW = 11;
  localparam int DW = W * H * WS;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic          sof = 1'b0;
  logic [WS-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [AW-1:0] col_out;
  logic [AW-1:0] row_out;
  logic          frame_end;

  line_window_generator #(
    .WORD_SIZE(WS), .WIDTH(W), .HEIGHT(H),
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .sof(sof), .din(din),
    .dout(dout), .dout_valid(dout_valid), .col_out(col_out),
    .row_out(row_out), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a picture of the current frame plus the next raster position.
  logic [WS-1:0] img [FH][FW];
  int            m_row = 0, m_col = 0;
  int            e_row = 0, e_col = 0;
  logic          e_valid = 1'b0, e_fe = 1'b0, e_win_chk = 1'b1;
  logic [DW-1:0] e_win = '0;

  // Observations gathered by test_stream for the scenario tasks.
  int            v_count;
  int            first_vr, first_vc;
  logic [DW-1:0] first_vdout;
  int            first_pr, first_pc;
  logic          fe_seen;
  logic [DW-1:0] fe_dout;

  task automatic model_reset();
    m_row = 0; m_col = 0; e_row = 0; e_col = 0;
    e_valid = 1'b0; e_fe = 1'b0; e_win = '0; e_win_chk = 1'b1;
  endtask

  task automatic model_accept(input logic [WS-1:0] px, input bit s);
    int r, c;
    r = s ? 0 : m_row;
    c = s ? 0 : m_col;
    img[r][c] = px;
    if (c == FW - 1) begin
      m_col = 0;
      m_row = (r == FH - 1) ? 0 : r + 1;
    end else begin
      m_col = c + 1;
      m_row = r;
    end
    e_row = r;
    e_col = c;
    e_fe  = (r == FH - 1) && (c == FW - 1);
`ifdef WINDOW_ZERO_PAD_EN
    e_valid = 1'b1;
`else
    e_valid = (r >= H - 1) && (c >= W - 1);
`endif
    e_win_chk = e_valid;
    for (int i = 0; i < H; i++) begin
      for (int j = 0; j < W; j++) begin
        e_win[(i*W+j+1)*WS-1 -: WS] = ((r - i) < 0 || (c - j) < 0) ? '0 : img[r-i][c-j];
      end
    end
  endtask

  function automatic logic [WS-1:0] lane(input logic [DW-1:0] v, input int l);
    return v[(l+1)*WS-1 -: WS];
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h want 0", dout); end
    n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    n_checks++; if (col_out !== '0 || row_out !== '0) begin n_fail++; $display("FAIL reset_pos got %0d,%0d want 0,0", row_out, col_out); end
    n_checks++; if (frame_end !== 1'b0) begin n_fail++; $display("FAIL reset_fe got %b want 0", frame_end); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_checks++; if (dout_valid !== 1'b0 || dout !== '0) begin n_fail++; $display("FAIL post_reset_idle got valid=%b dout=%h want 0", dout_valid, dout); end
  endtask

  // Streams npix pixels with en held high duty% of cycles; checks every cycle.
  task automatic test_stream(input int npix, input int duty, input bit first_sof, input bit rand_data);
    int   sent, cycles, r, c;
    bit   s;
    logic [WS-1:0] px;
    sent = 0; cycles = 0; v_count = 0;
    first_vr = -1; first_vc = -1; first_vdout = '0;
    first_pr = -1; first_pc = -1; fe_seen = 1'b0; fe_dout = '0;
    while (sent < npix) begin
      if (cycles > npix * 20 + 100) begin
        n_checks++; n_fail++;
        $display("FAIL stream_timeout got %0d pixels want %0d", sent, npix);
        break;
      end
      cycles++;
      @(negedge clk);
      if ($urandom_range(99) < duty) begin
        s  = first_sof && (sent == 0);
        r  = s ? 0 : m_row;
        c  = s ? 0 : m_col;
        px = rand_data ? WS'($urandom) : WS'(r * 16 + c);
        en = 1'b1; sof = s; din = px;
        model_accept(px, s);
        sent++;
      end else begin
        en = 1'b0; sof = 1'($urandom); din = WS'($urandom);
        e_valid = 1'b0; e_fe = 1'b0;
      end
      @(posedge clk); #1;
      n_checks++; if (dout_valid !== e_valid) begin n_fail++; $display("FAIL dout_valid @%0d,%0d got %b want %b", e_row, e_col, dout_valid, e_valid); end
      n_checks++; if (frame_end !== e_fe) begin n_fail++; $display("FAIL frame_end @%0d,%0d got %b want %b", e_row, e_col, frame_end, e_fe); end
      n_checks++; if (row_out !== AW'(e_row)) begin n_fail++; $display("FAIL row_out got %0d want %0d", row_out, e_row); end
      n_checks++; if (col_out !== AW'(e_col)) begin n_fail++; $display("FAIL col_out got %0d want %0d", col_out, e_col); end
      if (e_win_chk) begin
        n_checks++; if (dout !== e_win) begin n_fail++; $display("FAIL dout @%0d,%0d got %h want %h", e_row, e_col, dout, e_win); end
      end
      if (en && first_pr < 0) begin first_pr = int'(row_out); first_pc = int'(col_out); end
      if (dout_valid === 1'b1) begin
        v_count++;
        if (first_vr < 0) begin first_vr = int'(row_out); first_vc = int'(col_out); first_vdout = dout; end
        if (frame_end === 1'b1) begin fe_seen = 1'b1; fe_dout = dout; end
      end
      en = 1'b0; sof = 1'b0;
    end
  endtask

  task automatic test_full_frame();
    test_stream(FH * FW, 100, 1'b1, 1'b0);
`ifndef WINDOW_ZERO_PAD_EN
    n_checks++; if (v_count !== 24) begin n_fail++; $display("FAIL frame_valid_count got %0d want 24", v_count); end
    n_checks++; if (first_vr !== 2 || first_vc !== 2) begin n_fail++; $display("FAIL first_valid_pos got %0d,%0d want 2,2", first_vr, first_vc); end
    n_checks++; if (lane(first_vdout, 0) !== 8'h22 || lane(first_vdout, 4) !== 8'h11 || lane(first_vdout, 8) !== 8'h00) begin
      n_fail++; $display("FAIL first_window got %h want lanes 22/11/00", first_vdout);
    end
`endif
  endtask

  task automatic test_random_gaps();
    test_stream(FH * FW, 50, 1'b1, 1'b0);
`ifndef WINDOW_ZERO_PAD_EN
    n_checks++; if (v_count !== 24) begin n_fail++; $display("FAIL gap_valid_count got %0d want 24", v_count); end
    n_checks++; if (first_vr !== 2 || first_vc !== 2) begin n_fail++; $display("FAIL gap_first_pos got %0d,%0d want 2,2", first_vr, first_vc); end
`endif
  endtask

  task automatic test_frame_end();
    test_stream(FH * FW, 60, 1'b1, 1'b0);
    n_checks++; if (fe_seen !== 1'b1) begin n_fail++; $display("FAIL fe_seen got %b want 1", fe_seen); end
    n_checks++; if (lane(fe_dout, 0) !== 8'h57 || lane(fe_dout, 8) !== 8'h35) begin
      n_fail++; $display("FAIL fe_window got %h want lane0=57 lane8=35", fe_dout);
    end
    test_stream(1, 100, 1'b0, 1'b0);
    n_checks++; if (first_pr !== 0 || first_pc !== 0) begin n_fail++; $display("FAIL wrap_pos got %0d,%0d want 0,0", first_pr, first_pc); end
  endtask

  task automatic test_sof_mid_frame();
    test_stream(3 * FW + 4, 100, 1'b1, 1'b0);
    test_stream(FH * FW, 70, 1'b1, 1'b0);
    n_checks++; if (first_pr !== 0 || first_pc !== 0) begin n_fail++; $display("FAIL sof_pos got %0d,%0d want 0,0", first_pr, first_pc); end
`ifndef WINDOW_ZERO_PAD_EN
    n_checks++; if (first_vr !== 2 || first_vc !== 2) begin n_fail++; $display("FAIL sof_first_valid got %0d,%0d want 2,2", first_vr, first_vc); end
    n_checks++; if (v_count !== 24) begin n_fail++; $display("FAIL sof_valid_count got %0d want 24", v_count); end
`endif
  endtask

  task automatic test_async_reset();
    test_stream(2 * FW + 4, 100, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL areset_dout got %h want 0", dout); end
    n_checks++; if (dout_valid !== 1'b0 || frame_end !== 1'b0) begin n_fail++; $display("FAIL areset_flags got %b%b want 00", dout_valid, frame_end); end
    n_checks++; if (row_out !== '0 || col_out !== '0) begin n_fail++; $display("FAIL areset_pos got %0d,%0d want 0,0", row_out, col_out); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    test_full_frame();
  endtask

  task automatic test_random_data();
    test_stream(FH * FW, 70, 1'b1, 1'b1);
`ifndef WINDOW_ZERO_PAD_EN
    n_checks++; if (v_count !== 24) begin n_fail++; $display("FAIL rand_valid_count got %0d want 24", v_count); end
`endif
  endtask

`ifdef WINDOW_ZERO_PAD_EN
  task automatic test_zero_pad();
    logic [WS-1:0] px;
    for (int k = 0; k <= FW + 1; k++) begin
      @(negedge clk);
      px = WS'((k / FW) * 16 + (k % FW));
      en = 1'b1; sof = (k == 0); din = px;
      model_accept(px, k == 0);
      @(posedge clk); #1;
      en = 1'b0; sof = 1'b0;
      if (k == 0) begin
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL pad00_valid got %b want 1", dout_valid); end
        n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL pad00_dout got %h want 0", dout); end
      end
      if (k == FW + 1) begin
        n_checks++; if (lane(dout, 4) !== 8'h00 || lane(dout, 2) !== 8'h00) begin n_fail++; $display("FAIL pad11_lanes got %h want lane4=00 lane2=00", dout); end
        n_checks++; if (dout !== e_win) begin n_fail++; $display("FAIL pad11_dout got %h want %h", dout, e_win); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef WINDOW_ZERO_PAD_EN
    test_zero_pad();
`endif
    test_full_frame();
    test_random_gaps();
    test_frame_end();
    test_sof_mid_frame();
    test_async_reset();
    test_random_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_window_generator.md
Name: line_window_generator

Overview:
- Parametrised successor to the pixel-window generator used by the image kernels (filters, connected components).
- Accepts a raster-order pixel stream with a per-pixel enable.
- Builds a WIDTH x HEIGHT window from circular line buffers indexed by an internal column counter.
- Tracks row/column position and start of frame, and flags when the window is fully populated, so downstream kernels need no position logic.

Parameters:
- WORD_SIZE, `WORD_SIZE: bits per pixel.
- WIDTH, 3: window columns (>=1).
- HEIGHT, 3: window rows (>=1); HEIGHT-1 line buffers are instantiated.
- FRAME_WIDTH, `FRAME_WIDTH: pixels per line (> WIDTH).
- FRAME_HEIGHT, `FRAME_HEIGHT: lines per frame (> HEIGHT).
- ADDR_WIDTH, 11: column/row counter width; must hold FRAME_WIDTH-1 and FRAME_HEIGHT-1.

Ports:
- clk, input, 1: clock, all state on rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- en, input, 1: din valid; one pixel is accepted per cycle with en=1.
- sof, input, 1: start of frame; sampled only when en=1; marks din as pixel (0,0).
- din, input, WORD_SIZE: pixel in.
- dout, output, WIDTH*HEIGHT*WORD_SIZE: packed window; lane i*WIDTH+j occupies bits [(i*WIDTH+j+1)*WORD_SIZE-1 -: WORD_SIZE] and holds the pixel at (row-i, col-j).
- dout_valid, output, 1: window complete and updated this cycle.
- col_out, output, ADDR_WIDTH: column of the newest pixel (lane 0).
- row_out, output, ADDR_WIDTH: row of the newest pixel (lane 0).
- frame_end, output, 1: pulses with the window whose newest pixel is (FRAME_HEIGHT-1, FRAME_WIDTH-1).

Behaviour:
- Reset (async, reset_n=0):
  - col/row counters, window registers, dout, dout_valid, col_out, row_out and frame_end all go to 0.
  - Line-buffer RAM contents are not reset.
- Position counters:
  - col and row are the position of the next pixel to be accepted.
  - On en: col increments; at FRAME_WIDTH-1 it wraps to 0 and row increments.
  - row wraps to 0 after FRAME_HEIGHT-1.
  - en=1 with sof=1: the accepted pixel is taken as (0,0) regardless of the counters; next col=1, row=0.
  - sof with en=0 is ignored.
- Line buffers:
  - HEIGHT-1 circular RAMs, depth FRAME_WIDTH, all addressed by col.
  - Buffer k is read at col with read-old-data semantics; this gives the pixel at (row-k-1, col).
  - On the same en cycle, buffer k is written with the pixel at (row-k, col): din for k=0, buffer k-1's read data otherwise.
  - No read/write hazard exists: read and write share the address and old data is returned.
- Window shift (only when en=1; otherwise all window state holds):
  - p[0][0] <= din.
  - p[i][0] <= line buffer i-1 read data.
  - p[i][j] <= p[i][j-1] for j>=1.
- Latency: one cycle. dout, col_out, row_out, dout_valid and frame_end update on the edge that accepts the pixel and are valid the following cycle.
- dout_valid:
  - Registered; 1 for exactly one cycle per accepted pixel when row>=HEIGHT-1 and col>=WIDTH-1 (position of the accepted pixel).
  - Otherwise 0; it is 0 on any cycle with en=0.
- frame_end:
  - 1 for one cycle after accepting (FRAME_HEIGHT-1, FRAME_WIDTH-1).
  - Coincides with dout_valid=1.
- Wrap lanes: with dout_valid=0, lanes may contain pixels from the previous line or frame. Contents are unspecified except as defined by the optional feature.
- sof mid-frame: counters restart at (0,1) after the sof pixel. Stale buffer data is never flagged valid until HEIGHT-1 new rows have been received.
- en gaps: any number of idle cycles between pixels; behaviour is identical to back-to-back input.

Optional Feature:
- Macro: WINDOW_ZERO_PAD_EN.
- When defined:
  - Lanes (i,j) with row-i<0 or col-j<0 are output as 0.
  - dout_valid=1 for every accepted pixel, including border positions.
  - The output window is a zero-padded border window.
- When undefined: no masking logic is built, and dout_valid follows the completeness rule above.

Test Plan (WIDTH=3, HEIGHT=3, FRAME_WIDTH=8, FRAME_HEIGHT=6, WORD_SIZE=8, din=row*16+col):
- Reset, then a full frame back-to-back with sof on the first pixel:
  - dout_valid is first 1 the cycle after pixel (2,2), with lane0=0x22, lane4=0x11, lane8=0x00.
  - dout_valid asserts 24 times per frame.
- Same frame with en toggled at random, about 50% duty:
  - Identical dout/col_out/row_out sequence at each dout_valid.
  - All outputs stable while en=0.
- Last pixel (5,7):
  - frame_end=1 and dout_valid=1 in the same cycle, lane0=0x57, lane8=0x35.
  - Next frame's first pixel gives row_out=0, col_out=0.
- sof asserted at pixel (3,4) of a frame:
  - That pixel reports row_out=0, col_out=0.
  - No dout_valid until new row 2, col 2.
- Assert reset_n=0 asynchronously mid-row (no clock edge):
  - All outputs go to 0 immediately.
  - After release, a normal frame reproduces the first scenario.
- With WINDOW_ZERO_PAD_EN: pixel (0,0) gives dout_valid=1, lane0=0x00, all other lanes 0; pixel (1,1) gives lane4=0x00, lane2=0.
